// File: rtl/e203_exu_disp_fwd_pkg.sv
// Shared defaults for the dispatch/forwarding slice.
// Widths and depths used when no override is given.
package e203_exu_disp_fwd_pkg;

    localparam int E203_FWD_XLEN      = 32;
    localparam int E203_FWD_RFIDX_W   = 5;
    localparam int E203_FWD_NWB       = 2;
    localparam int E203_FWD_DEPTH     = 2;
    localparam int E203_FWD_NRS       = 2;
    localparam int E203_FWD_PAYLOAD_W = 64;
    localparam int E203_FWD_CNT_W     = 16;

endpackage

// File: rtl/e203_exu_disp_fwd_if.sv
// Dispatch, write-back and staged-output signal bundle.
// master drives requests and write-backs, slave is the forwarding block.
interface e203_exu_disp_fwd_if
    import e203_exu_disp_fwd_pkg::*;
#(
    parameter int XLEN      = E203_FWD_XLEN,
    parameter int RFIDX_W   = E203_FWD_RFIDX_W,
    parameter int NWB       = E203_FWD_NWB,
    parameter int NRS       = E203_FWD_NRS,
    parameter int PAYLOAD_W = E203_FWD_PAYLOAD_W
);

    logic [NWB-1:0]         wb_valid;
    logic [NWB-1:0]         wb_rdwen;
    logic [NWB*RFIDX_W-1:0] wb_rdidx;
    logic [NWB*XLEN-1:0]    wb_wdat;

    logic                   i_valid;
    logic                   i_ready;
    logic [NRS-1:0]         i_rsen;
    logic [NRS*RFIDX_W-1:0] i_rsidx;
    logic [NRS*XLEN-1:0]    i_rsdat;
    logic [NRS-1:0]         i_oitf_match;
    logic                   i_waw_dep;
    logic [PAYLOAD_W-1:0]   i_payload;

    logic                   o_valid;
    logic                   o_ready;
    logic [NRS*XLEN-1:0]    o_rsdat;
    logic [NRS-1:0]         o_fwd_hit;
    logic [PAYLOAD_W-1:0]   o_payload;

    modport master (
        output wb_valid, wb_rdwen, wb_rdidx, wb_wdat,
        output i_valid, i_rsen, i_rsidx, i_rsdat,
        output i_oitf_match, i_waw_dep, i_payload,
        output o_ready,
        input  i_ready, o_valid, o_rsdat, o_fwd_hit, o_payload
    );

    modport slave (
        input  wb_valid, wb_rdwen, wb_rdidx, wb_wdat,
        input  i_valid, i_rsen, i_rsidx, i_rsdat,
        input  i_oitf_match, i_waw_dep, i_payload,
        input  o_ready,
        output i_ready, o_valid, o_rsdat, o_fwd_hit, o_payload
    );

endinterface

// File: rtl/e203_exu_disp_fwd_hist.sv
// Priority lookup of one source operand against live write-back
// and the shared write-back history (entry e = age*NWB + channel).
module e203_exu_disp_fwd_hist
    import e203_exu_disp_fwd_pkg::*;
#(
    parameter int XLEN    = E203_FWD_XLEN,
    parameter int RFIDX_W = E203_FWD_RFIDX_W,
    parameter int NWB     = E203_FWD_NWB,
    parameter int DEPTH   = E203_FWD_DEPTH
) (
    input  logic                         i_rsen,
    input  logic [RFIDX_W-1:0]           i_rsidx,
    input  logic [XLEN-1:0]              i_rsdat,
    input  logic [NWB-1:0]               i_wb_live,
    input  logic [NWB*RFIDX_W-1:0]       i_wb_rdidx,
    input  logic [NWB*XLEN-1:0]          i_wb_wdat,
    input  logic [NWB*DEPTH-1:0]         i_hv,
    input  logic [NWB*DEPTH*RFIDX_W-1:0] i_hidx,
    input  logic [NWB*DEPTH*XLEN-1:0]    i_hdat,
    output logic [XLEN-1:0]              o_dat,
    output logic                         o_live_hit,
    output logic                         o_hit
);

    localparam int NE = NWB * DEPTH;

    logic w_en;

    assign w_en = i_rsen & (i_rsidx != '0);

    // Scan lowest priority first so the highest-priority match is written last.
    always_comb begin
        o_dat      = '0;
        o_live_hit = 1'b0;
        o_hit      = 1'b0;
        if (w_en) begin
            o_dat = i_rsdat;
            for (int e = NE - 1; e >= 0; e--) begin
                if (i_hv[e] && (i_hidx[e*RFIDX_W +: RFIDX_W] == i_rsidx)) begin
                    o_dat = i_hdat[e*XLEN +: XLEN];
                    o_hit = 1'b1;
                end
            end
            for (int c = NWB - 1; c >= 0; c--) begin
                if (i_wb_live[c] && (i_wb_rdidx[c*RFIDX_W +: RFIDX_W] == i_rsidx)) begin
                    o_dat      = i_wb_wdat[c*XLEN +: XLEN];
                    o_hit      = 1'b1;
                    o_live_hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/e203_exu_disp_fwd.sv
// Operand forwarding and dispatch staging between regfile read and issue.
// Holds the write-back history, hazard stall, output stage and statistics.
module e203_exu_disp_fwd
    import e203_exu_disp_fwd_pkg::*;
#(
    parameter int XLEN      = E203_FWD_XLEN,
    parameter int RFIDX_W   = E203_FWD_RFIDX_W,
    parameter int NWB       = E203_FWD_NWB,
    parameter int DEPTH     = E203_FWD_DEPTH,
    parameter int NRS       = E203_FWD_NRS,
    parameter int PAYLOAD_W = E203_FWD_PAYLOAD_W,
    parameter int CNT_W     = E203_FWD_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    e203_exu_disp_fwd_if.slave  io,
    output logic [CNT_W-1:0]    stat_fwd_cnt,
    output logic [CNT_W-1:0]    stat_stall_cnt
);

    localparam int NE = NWB * DEPTH;

    logic [NE-1:0]           r_hv;
    logic [NE*RFIDX_W-1:0]   r_hidx;
    logic [NE*XLEN-1:0]      r_hdat;

    logic                    r_valid;
    logic [NRS*XLEN-1:0]     r_rsdat;
    logic [NRS-1:0]          r_hit;
    logic [PAYLOAD_W-1:0]    r_payload;
    logic [CNT_W-1:0]        r_fwd_cnt;
    logic [CNT_W-1:0]        r_stall_cnt;

    logic [NWB-1:0]          w_wb_live;
    logic [NRS*XLEN-1:0]     w_rsdat;
    logic [NRS-1:0]          w_live_hit;
    logic [NRS-1:0]          w_hit;
    logic                    w_haz;
    logic                    w_accept;

    for (genvar c = 0; c < NWB; c++) begin : g_live
        assign w_wb_live[c] = io.wb_valid[c] & io.wb_rdwen[c]
                            & (io.wb_rdidx[c*RFIDX_W +: RFIDX_W] != '0);
    end

    for (genvar k = 0; k < NRS; k++) begin : g_rs
        e203_exu_disp_fwd_hist #(
            .XLEN    (XLEN),
            .RFIDX_W (RFIDX_W),
            .NWB     (NWB),
            .DEPTH   (DEPTH)
        ) u_hist (
            .i_rsen     (io.i_rsen[k]),
            .i_rsidx    (io.i_rsidx[k*RFIDX_W +: RFIDX_W]),
            .i_rsdat    (io.i_rsdat[k*XLEN +: XLEN]),
            .i_wb_live  (w_wb_live),
            .i_wb_rdidx (io.wb_rdidx),
            .i_wb_wdat  (io.wb_wdat),
            .i_hv       (r_hv),
            .i_hidx     (r_hidx),
            .i_hdat     (r_hdat),
            .o_dat      (w_rsdat[k*XLEN +: XLEN]),
            .o_live_hit (w_live_hit[k]),
            .o_hit      (w_hit[k])
        );
    end

    // A history hit cannot clear an OITF match: only live write-back can.
    assign w_haz = io.i_waw_dep | (|(io.i_rsen & io.i_oitf_match & ~w_live_hit));

    assign io.i_ready = ~rst & ~flush & ~w_haz & (~r_valid | io.o_ready);
    assign w_accept   = io.i_valid & io.i_ready;

    // History shift register: age0 takes live GPR writes, older ages shift down.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_hv   <= '0;
            r_hidx <= '0;
            r_hdat <= '0;
        end else begin
            for (int c = 0; c < NWB; c++) begin
                r_hv[c]                      <= w_wb_live[c];
                r_hidx[c*RFIDX_W +: RFIDX_W] <= io.wb_rdidx[c*RFIDX_W +: RFIDX_W];
                r_hdat[c*XLEN +: XLEN]       <= io.wb_wdat[c*XLEN +: XLEN];
            end
            for (int e = NWB; e < NE; e++) begin
                r_hv[e]                      <= r_hv[e-NWB];
                r_hidx[e*RFIDX_W +: RFIDX_W] <= r_hidx[(e-NWB)*RFIDX_W +: RFIDX_W];
                r_hdat[e*XLEN +: XLEN]       <= r_hdat[(e-NWB)*XLEN +: XLEN];
            end
        end
    end

    // One-entry output stage; captured data is frozen until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_rsdat   <= '0;
            r_hit     <= '0;
            r_payload <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_rsdat   <= w_rsdat;
            r_hit     <= w_hit;
            r_payload <= io.i_payload;
        end else if (io.o_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating statistics; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && (|w_hit) && (r_fwd_cnt != '1))
                r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
            if (io.i_valid && w_haz && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign io.o_valid   = r_valid;
    assign io.o_rsdat   = r_rsdat;
    assign io.o_fwd_hit = r_hit;
    assign io.o_payload = r_payload;
    assign stat_fwd_cnt   = r_fwd_cnt;
    assign stat_stall_cnt = r_stall_cnt;

endmodule
